conv_win_feeder: RTL and testbench

- Downstream neighbour of the conv row-window controller.
- When that controller reports a window buffer is loaded (data_ready), this block streams the buffer contents into the systolic array. The buffer holds channel × row_ksize words, each word packing LANES pixels.
- Output is skewed into a diagonal wavefront: lane i is delayed i beats.
- The block flushes the skew, pulses done, and the host can then resume the controller for the next row window.

---
 rtl/conv_win_feeder.sv | 187 ++++++++++++++++++
 tb/tb_conv_win_feeder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_win_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_win_feeder: streams a loaded row-window buffer into the systolic    |
// | array as a lane-skewed wavefront. Option macro: FEEDER_STALL_CNT_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_win_feeder #(
    parameter int LANES     = 4,
    parameter int PIX_BITS  = 8,
    parameter int ADDR_BITS = 16,
    parameter int CFG_BITS  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CFG_BITS-1:0]       channel,
    input  logic [CFG_BITS-1:0]       row_ksize,
    output logic                      busy,
    output logic                      done,
    output logic                      buf_ren,
    output logic [ADDR_BITS-1:0]      buf_addr,
    input  logic [LANES*PIX_BITS-1:0] buf_DI,
    output logic                      feed_valid,
    input  logic                      feed_ready,
    output logic [LANES*PIX_BITS-1:0] feed_data
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam int WORD_BITS = LANES * PIX_BITS;
    localparam int CNT_BITS  = ADDR_BITS + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   n_words;
    logic [CNT_BITS-1:0]    ld_cnt;
    logic [CNT_BITS-1:0]    beat_cnt;
    logic                   rd_pending;
    logic                   stage_hold;
    logic [WORD_BITS-1:0]   stage_q;

    logic                   accept;
    logic [ADDR_BITS-1:0]   cfg_n;
    logic [CNT_BITS-1:0]    total;
    logic                   stage_valid;
    logic [WORD_BITS-1:0]   stage_word;
    logic                   from_stage;
    logic                   src_valid;
    logic [WORD_BITS-1:0]   src_word;
    logic                   load;
    logic                   consume;
    logic                   beat;
    logic [WORD_BITS-1:0]   next_data;

    assign accept      = start && (state == IDLE);
    assign cfg_n       = ADDR_BITS'(channel) * ADDR_BITS'(row_ksize);
    assign total       = {1'b0, n_words} + CNT_BITS'(LANES - 1);
    // The word on buf_DI counts as staged in its arrival cycle so one read per cycle is sustainable.
    assign stage_valid = rd_pending || stage_hold;
    assign stage_word  = rd_pending ? buf_DI : stage_q;
    assign from_stage  = ld_cnt < {1'b0, n_words};
    assign src_valid   = from_stage ? stage_valid : (ld_cnt < total);
    assign src_word    = from_stage ? stage_word : '0;
    assign load        = ((state == READ) || (state == DRAIN)) && src_valid
                         && (!feed_valid || feed_ready);
    assign consume     = load && from_stage;
    assign beat        = feed_valid && feed_ready;
    assign buf_ren     = (state == READ) && (buf_addr < n_words)
                         && (!stage_valid || consume);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign next_data[0 +: PIX_BITS] = src_word[0 +: PIX_BITS];
        end else begin : g_skew
            logic [PIX_BITS-1:0] line [i];
            assign next_data[i*PIX_BITS +: PIX_BITS] = line[i-1];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < i; k++) line[k] <= '0;
                end else if (accept) begin
                    for (int k = 0; k < i; k++) line[k] <= '0;
                end else if (load) begin
                    line[0] <= src_word[i*PIX_BITS +: PIX_BITS];
                    for (int k = 1; k < i; k++) line[k] <= line[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            buf_addr   <= '0;
            feed_valid <= 1'b0;
            feed_data  <= '0;
            n_words    <= '0;
            ld_cnt     <= '0;
            beat_cnt   <= '0;
            rd_pending <= 1'b0;
            stage_hold <= 1'b0;
            stage_q    <= '0;
        end else begin
            rd_pending <= buf_ren;
            if (buf_ren) buf_addr <= buf_addr + ADDR_BITS'(1);

            if (consume) begin
                stage_hold <= 1'b0;
            end else if (rd_pending) begin
                stage_hold <= 1'b1;
                stage_q    <= buf_DI;
            end

            if (load) begin
                ld_cnt     <= ld_cnt + CNT_BITS'(1);
                feed_data  <= next_data;
                feed_valid <= 1'b1;
            end else if (beat) begin
                feed_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        n_words  <= cfg_n;
                        busy     <= 1'b1;
                        buf_addr <= '0;
                        ld_cnt   <= '0;
                        beat_cnt <= '0;
                        state    <= (cfg_n == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + CNT_BITS'(1);
                        if (beat_cnt + CNT_BITS'(1) == {1'b0, n_words}) begin
                            if (LANES > 1) begin
                                state <= DRAIN;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + CNT_BITS'(1);
                        if (beat_cnt + CNT_BITS'(1) == total) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // An empty window enters without the pulse and raises it one cycle later.
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (feed_valid && !feed_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_win_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_win_feeder: scoreboard bench for conv_win_feeder.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_conv_win_feeder;

    localparam int LANES = 4;
    localparam int W     = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    channel = '0;
    logic [7:0]    row_ksize = '0;
    logic          busy, done, buf_ren, feed_valid;
    logic [15:0]   buf_addr;
    logic [W-1:0]  buf_DI = '0;
    logic          feed_ready = 1'b1;
    logic [W-1:0]  feed_data;
`ifdef FEEDER_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    conv_win_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .channel    (channel),
        .row_ksize  (row_ksize),
        .busy       (busy),
        .done       (done),
        .buf_ren    (buf_ren),
        .buf_addr   (buf_addr),
        .buf_DI     (buf_DI),
        .feed_valid (feed_valid),
        .feed_ready (feed_ready),
        .feed_data  (feed_data)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        bit           last;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           beats_seen = 0;
    int           done_cnt = 0;
    int           ren_total = 0;
    int           hits[16];
    int           hits_snap[16];
    logic [W-1:0] beat_log[128];
    bit           expect_done = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Buffer word k packs the value k+1 into every lane.
    always @(posedge clk) begin
        if (rst && buf_ren) begin
            ren_total++;
            if (buf_addr < 16) hits[buf_addr]++;
            buf_DI <= {LANES{8'(buf_addr + 16'd1)}};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            expect_done = 0;
            prev_stall  = 0;
        end else begin
            if (expect_done) begin
                check("done_after_last_beat", done, 1);
                expect_done = 0;
            end
            if (done) done_cnt++;
            if (feed_valid && prev_stall) check("stall_data_hold", feed_data, prev_data);
            prev_stall = feed_valid && !feed_ready;
            prev_data  = feed_data;
            if (feed_valid && feed_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", feed_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_data", feed_data, e.data);
                    expect_done = e.last;
                end
                if (beats_seen < 128) beat_log[beats_seen] = feed_data;
                beats_seen++;
            end
        end
    end

    task automatic push_window(input int n);
        for (int j = 0; j < n + LANES - 1; j++) begin
            exp_t e;
            e.data = '0;
            for (int i = 0; i < LANES; i++) begin
                if ((j - i >= 0) && (j - i < n)) e.data[i*8 +: 8] = 8'(j - i + 1);
            end
            e.last = (j == n + LANES - 2);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_win(input logic [7:0] ch, input logic [7:0] rk);
        channel   = ch;
        row_ksize = rk;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int t;
        for (t = 0; t < budget && done_cnt <= d0; t++) tick();
        if (done_cnt <= d0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic wait_beats(input int target, input int budget);
        for (int t = 0; t < budget && beats_seen < target; t++) tick();
        if (beats_seen < target) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", beats_seen, target);
        end
    endtask

    task automatic snap_hits();
        for (int a = 0; a < 16; a++) hits_snap[a] = hits[a];
    endtask

    task automatic check_reads(input int r0);
        check("read_count", ren_total - r0, 6);
        for (int a = 0; a < 6; a++) check("addr_read_once", hits[a] - hits_snap[a], 1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_buf_ren"}, buf_ren, 0);
        check({name, "_feed_valid"}, feed_valid, 0);
        check({name, "_buf_addr"}, buf_addr, 0);
        check({name, "_feed_data"}, feed_data, 0);
    endtask

    initial begin
        int b0, d0, r0, r1;
        for (int a = 0; a < 16; a++) hits[a] = 0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        tick();

        // Basic 2x3 window with feed_ready held high.
        b0 = beats_seen; d0 = done_cnt; r0 = ren_total; snap_hits();
        push_window(6);
        start_win(8'd2, 8'd3);
        check("busy_after_start", busy, 1);
        wait_done(d0, 100);
        check("basic_beat0", beat_log[b0], 32'h00000001);
        check("basic_beat3", beat_log[b0+3], 32'h01020304);
        check("basic_beat8", beat_log[b0+8], 32'h06000000);
        check("basic_beat_count", beats_seen - b0, 9);
        check_reads(r0);
        check("busy_after_done", busy, 0);

        // Backpressure: three stall cycles on beats 2 and 5.
        b0 = beats_seen; d0 = done_cnt; r0 = ren_total; snap_hits();
        push_window(6);
        start_win(8'd2, 8'd3);
        wait_beats(b0 + 2, 50);
        feed_ready = 1'b0;
        repeat (3) tick();
        feed_ready = 1'b1;
        wait_beats(b0 + 5, 50);
        feed_ready = 1'b0;
        repeat (3) tick();
        feed_ready = 1'b1;
        wait_done(d0, 100);
        check("bp_beat_count", beats_seen - b0, 9);
        check_reads(r0);
`ifdef FEEDER_STALL_CNT_EN
        tick();
        check("stall_cnt", stall_cnt, 6);
`endif

        // Empty window: done two cycles after start, no reads.
        r0 = ren_total; d0 = done_cnt;
        start_win(8'd0, 8'd3);
        check("zero_c1_done", done, 0);
        check("zero_c1_busy", busy, 1);
        tick();
        check("zero_c2_done", done, 1);
        check("zero_c2_busy", busy, 1);
        check("zero_c2_valid", feed_valid, 0);
        tick();
        check("zero_c3_done", done, 0);
        check("zero_c3_busy", busy, 0);
        check("zero_reads", ren_total - r0, 0);

        // A second start during READ is ignored.
        b0 = beats_seen; d0 = done_cnt; r0 = ren_total; snap_hits();
        push_window(6);
        start_win(8'd2, 8'd3);
        repeat (3) tick();
        start_win(8'd1, 8'd1);
        wait_done(d0, 100);
        repeat (5) tick();
        check("busy_start_done_count", done_cnt - d0, 1);
        check("busy_start_beat_count", beats_seen - b0, 9);
        check_reads(r0);

        // Reset after beat 4, then a clean restart.
        b0 = beats_seen;
        push_window(6);
        start_win(8'd2, 8'd3);
        wait_beats(b0 + 5, 50);
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        tick();
        tick();
        rst = 1'b1;
        tick();
        r1 = ren_total;
        repeat (4) tick();
        check("no_reread_after_reset", ren_total - r1, 0);
        check("idle_after_reset", busy, 0);
        b0 = beats_seen; d0 = done_cnt; r0 = ren_total; snap_hits();
        push_window(6);
        start_win(8'd2, 8'd3);
        wait_done(d0, 100);
        check("restart_beat0", beat_log[b0], 32'h00000001);
        check("restart_beat_count", beats_seen - b0, 9);
        check_reads(r0);

        // Back-to-back: next start in the cycle right after done.
        d0 = done_cnt;
        push_window(6);
        start_win(8'd2, 8'd3);
        wait_done(d0, 100);
        b0 = beats_seen; d0 = done_cnt;
        push_window(2);
        start_win(8'd1, 8'd2);
        check("b2b_accepted", busy, 1);
        wait_done(d0, 100);
        check("b2b_beat0", beat_log[b0], 32'h00000001);
        check("b2b_beat3", beat_log[b0+3], 32'h01020000);
        check("b2b_beat_count", beats_seen - b0, 5);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
